// File: rtl/cpu_pkg.sv
// Shared core definitions: default widths, bubble encoding and fetch FSM states.
package cpu_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned INSN_W = 32;

    // add $r0,$r0,$r0 -- harmless if a consumer ignores the valid bit
    localparam logic [INSN_W-1:0] NOP_INSN = '0;

    typedef enum logic {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fd_pipe_reg.sv
// F/D pipeline register: async active-low reset, hold when !en_i, flush to bubble (wins over enable).
module fd_pipe_reg #(
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned INSN_W = cpu_pkg::INSN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic [INSN_W-1:0] insn_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] pc_plus1_i,
    input  logic              valid_i,
    output logic [INSN_W-1:0] insn_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus1_o,
    output logic              valid_o
);
    import cpu_pkg::*;

    logic [INSN_W-1:0] insn_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_plus1_q;
    logic              valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_q     <= INSN_W'(NOP_INSN);
            pc_q       <= '0;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            insn_q     <= INSN_W'(NOP_INSN);
            pc_q       <= '0;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
        end else if (en_i) begin
            insn_q     <= insn_i;
            pc_q       <= pc_i;
            pc_plus1_q <= pc_plus1_i;
            valid_q    <= valid_i;
        end
    end

    assign insn_o     = insn_q;
    assign pc_o       = pc_q;
    assign pc_plus1_o = pc_plus1_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives synchronous imem, feeds the F/D register to decode.
module fetch_stage #(
    parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned INSN_W   = cpu_pkg::INSN_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSN_W-1:0] imem_q,
    output logic [INSN_W-1:0] fd_insn,
    output logic [ADDR_W-1:0] fd_pc,
    output logic [ADDR_W-1:0] fd_pc_plus1,
    output logic              fd_valid,
    output logic [CNT_W-1:0]  stall_count
);
    import cpu_pkg::*;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [CNT_W-1:0]  cnt_q;
    logic              run;

    assign run    = (state_q == FETCH_RUN);
    assign pc_inc = pc_q + ADDR_W'(1);

    // The address sent to imem is always the next PC, keeping imem_q aligned with pc_q in RUN.
    always_comb begin
        pc_d = pc_q;
        if (redirect_en)
            pc_d = redirect_pc;
        else if (run && !stall)
            pc_d = pc_inc;
    end

    assign imem_addr = pc_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= FETCH_RUN;
            pc_q    <= pc_d;
            if (run && !redirect_en && stall && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_count = cnt_q;

    fd_pipe_reg #(
        .ADDR_W (ADDR_W),
        .INSN_W (INSN_W)
    ) u_fd (
        .clk        (clock),
        .rst_n      (reset),
        .en_i       (!stall),
        .flush_i    (redirect_en || !run),
        .insn_i     (imem_q),
        .pc_i       (pc_q),
        .pc_plus1_i (pc_inc),
        .valid_i    (1'b1),
        .insn_o     (fd_insn),
        .pc_o       (fd_pc),
        .pc_plus1_o (fd_pc_plus1),
        .valid_o    (fd_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table-driven vectors with a scoreboard queue plus reset and saturation sequences.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic [11:0] imem_addr;
    logic [31:0] imem_q = '0;
    logic [31:0] fd_insn;
    logic [11:0] fd_pc;
    logic [11:0] fd_pc_plus1;
    logic        fd_valid;
    logic [15:0] stall_count;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_stage #(
        .ADDR_W   (12),
        .INSN_W   (32),
        .RESET_PC (12'h000),
        .CNT_W    (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .fd_insn     (fd_insn),
        .fd_pc       (fd_pc),
        .fd_pc_plus1 (fd_pc_plus1),
        .fd_valid    (fd_valid),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memw(input logic [11:0] a);
        return 32'hA500_0000 ^ {a, 8'h00, a};
    endfunction

    // synchronous imem: data one clock after the address
    always @(posedge clock) imem_q <= memw(imem_addr);

    typedef struct {
        bit          stall;
        bit          redir;
        logic [11:0] rpc;
        logic [11:0] e_addr;
        bit          e_valid;
        logic [31:0] e_insn;
        logic [11:0] e_pc;
        logic [11:0] e_pcp1;
        int          e_cnt;   // -1: not checked
    } vec_t;

    vec_t tbl[17];
    vec_t sb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit s, input bit r, input logic [11:0] rpc,
                                input logic [11:0] ea, input bit ev, input logic [31:0] ei,
                                input logic [11:0] ep, input logic [11:0] ep1, input int ec);
        vec_t v;
        v.stall = s; v.redir = r; v.rpc = rpc; v.e_addr = ea; v.e_valid = ev;
        v.e_insn = ei; v.e_pc = ep; v.e_pcp1 = ep1; v.e_cnt = ec;
        return v;
    endfunction

    // Called at a negedge: drive, check address, clock once, compare F/D against the scoreboard.
    task automatic apply(input int idx);
        vec_t v, e;
        v = tbl[idx];
        stall = v.stall; redirect_en = v.redir; redirect_pc = v.rpc;
        #1;
        check($sformatf("imem_addr[%0d]", idx), 32'(imem_addr), 32'(v.e_addr));
        sb.push_back(v);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check($sformatf("fd_valid[%0d]", idx), 32'(fd_valid), 32'(e.e_valid));
        check($sformatf("fd_insn[%0d]", idx), fd_insn, e.e_insn);
        check($sformatf("fd_pc[%0d]", idx), 32'(fd_pc), 32'(e.e_pc));
        check($sformatf("fd_pc_plus1[%0d]", idx), 32'(fd_pc_plus1), 32'(e.e_pcp1));
        if (e.e_cnt >= 0)
            check($sformatf("stall_count[%0d]", idx), 32'(stall_count), e.e_cnt);
        @(negedge clock);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " fd_valid"}, 32'(fd_valid), 0);
        check({tag, " fd_insn"}, fd_insn, 0);
        check({tag, " fd_pc"}, 32'(fd_pc), 0);
        check({tag, " fd_pc_plus1"}, 32'(fd_pc_plus1), 0);
        check({tag, " stall_count"}, 32'(stall_count), 0);
        check({tag, " imem_addr"}, 32'(imem_addr), 0);
    endtask

    task automatic pulse_reset(input string tag);
        stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        #2 reset = 1'b0;
        #1 check_reset_state(tag);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 12'h000, 12'h000, 0, 32'h0,          12'h000, 12'h000, 0);
        tbl[1]  = mk(0, 0, 12'h000, 12'h001, 1, memw(12'h000), 12'h000, 12'h001, 0);
        tbl[2]  = mk(0, 0, 12'h000, 12'h002, 1, memw(12'h001), 12'h001, 12'h002, 0);
        tbl[3]  = mk(1, 0, 12'h000, 12'h002, 1, memw(12'h001), 12'h001, 12'h002, 1);
        tbl[4]  = mk(1, 0, 12'h000, 12'h002, 1, memw(12'h001), 12'h001, 12'h002, 2);
        tbl[5]  = mk(1, 0, 12'h000, 12'h002, 1, memw(12'h001), 12'h001, 12'h002, 3);
        tbl[6]  = mk(0, 0, 12'h000, 12'h003, 1, memw(12'h002), 12'h002, 12'h003, 3);
        tbl[7]  = mk(1, 1, 12'h100, 12'h100, 0, 32'h0,          12'h000, 12'h000, -1);
        tbl[8]  = mk(0, 0, 12'h000, 12'h101, 1, memw(12'h100), 12'h100, 12'h101, -1);
        tbl[9]  = mk(0, 1, 12'hFFE, 12'hFFE, 0, 32'h0,          12'h000, 12'h000, -1);
        tbl[10] = mk(0, 0, 12'h000, 12'hFFF, 1, memw(12'hFFE), 12'hFFE, 12'hFFF, -1);
        tbl[11] = mk(0, 0, 12'h000, 12'h000, 1, memw(12'hFFF), 12'hFFF, 12'h000, -1);
        tbl[12] = mk(0, 0, 12'h000, 12'h001, 1, memw(12'h000), 12'h000, 12'h001, -1);
        // after reset: stall ignored in BOOT
        tbl[13] = mk(1, 0, 12'h000, 12'h000, 0, 32'h0,          12'h000, 12'h000, 0);
        tbl[14] = mk(0, 0, 12'h000, 12'h001, 1, memw(12'h000), 12'h000, 12'h001, 0);
        // after reset: redirect taken in BOOT
        tbl[15] = mk(0, 1, 12'h200, 12'h200, 0, 32'h0,          12'h000, 12'h000, 0);
        tbl[16] = mk(0, 0, 12'h000, 12'h201, 1, memw(12'h200), 12'h200, 12'h201, 0);

        #1 check_reset_state("por");
        repeat (2) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i <= 12; i++) apply(i);

        pulse_reset("midrst");
        for (int i = 13; i <= 14; i++) apply(i);

        pulse_reset("bootredir");
        for (int i = 15; i <= 16; i++) apply(i);

        // long stall: counter saturates, PC and F/D frozen
        stall = 1'b1;
        repeat (65534) @(posedge clock);
        #1 check("cnt_pre_sat", 32'(stall_count), 32'hFFFE);
        repeat (7) @(posedge clock);
        #1;
        check("cnt_sat", 32'(stall_count), 32'hFFFF);
        check("sat_imem_addr", 32'(imem_addr), 32'h201);
        check("sat_fd_pc", 32'(fd_pc), 32'h200);
        check("sat_fd_insn", fd_insn, memw(12'h200));
        check("sat_fd_valid", 32'(fd_valid), 1);

        @(negedge clock);
        stall = 1'b0;
        #1 check("post_sat_addr", 32'(imem_addr), 32'h202);
        @(posedge clock);
        #1 check("post_sat_insn", fd_insn, memw(12'h201));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
